// File: rtl/alu_pkg.sv
// Opcodes, field widths and sequencer state encoding shared by the ALU issue slice.
package alu_pkg;
  localparam int OPCODE_W = 4;
  localparam int SHIFT_W  = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_ROL   = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_PASSB = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_ROR   = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_MUL   = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  function automatic logic op_has_carry(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcodes 8..15 are exactly those with the top bit set.
  function automatic logic op_is_illegal(input logic [OPCODE_W-1:0] op);
    return op[OPCODE_W-1];
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO, head combinationally visible on pop_dat; 1-cycle push-to-pop latency.
// Pushes while full and pops while empty are ignored, so the caller gates on full/empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap on their natural width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end
endmodule

// File: rtl/alu_issue_sequencer.sv
// Buffers tagged commands, drives held operands into the combinational ALU and registers its result.
// Latency 2 cycles (+MUL_LATENCY for MUL); cmd_ready is FIFO-not-full, responses held until rsp_ready.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH       = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPCODE_W-1:0] cmd_opcode,
  input  logic [WIDTH-1:0]    cmd_a,
  input  logic [WIDTH-1:0]    cmd_b,
  input  logic [SHIFT_W-1:0]  cmd_shift,
  input  logic [TAG_W-1:0]    cmd_tag,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [WIDTH-1:0]    alu_input1,
  output logic [WIDTH-1:0]    alu_input2,
  output logic [SHIFT_W-1:0]  alu_shiftValue,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_carry,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic                rsp_carry,
  output logic                rsp_illegal,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy
);
  localparam int CNT_W = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [SHIFT_W-1:0]  shift;
    logic [TAG_W-1:0]    tag;
  } cmd_t;

  cmd_t             fifo_in;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic             pop;
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;

  function automatic logic [CNT_W-1:0] hold_cycles(input logic [OPCODE_W-1:0] op);
    return (op == OP_MUL) ? CNT_W'(MUL_LATENCY) : '0;
  endfunction

  assign fifo_in   = {cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag};
  assign cmd_ready = !fifo_full;
  // Pop from IDLE, or straight out of RESP on the consuming edge to avoid an IDLE bubble.
  assign pop  = !fifo_empty && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign busy = (fifo_count != '0) || (state != ST_IDLE);

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_dat (fifo_in),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      tag_q          <= '0;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_carry      <= 1'b0;
      rsp_illegal    <= 1'b0;
      rsp_tag        <= '0;
    end else begin
      if (pop) begin
        alu_opcode     <= head.opcode;
        alu_input1     <= head.a;
        alu_input2     <= head.b;
        alu_shiftValue <= head.shift;
        tag_q          <= head.tag;
        cnt            <= hold_cycles(head.opcode);
        state          <= ST_EXEC;
      end
      case (state)
        ST_EXEC: begin
          // Operands stay untouched while cnt drains, covering the MUL multicycle path.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_valid   <= 1'b1;
            rsp_result  <= alu_result;
            rsp_carry   <= alu_carry && op_has_carry(alu_opcode);
            rsp_illegal <= op_is_illegal(alu_opcode);
            rsp_tag     <= tag_q;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!pop) state <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: stand-in ALU, directed vector table, backpressure/reset sequences,
// and random traffic against an in-order response queue.
module tb_alu_issue_sequencer;
  import alu_pkg::*;

  localparam int W     = 128;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int ML    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [OPCODE_W-1:0] cmd_opcode;
  logic [W-1:0]        cmd_a;
  logic [W-1:0]        cmd_b;
  logic [SHIFT_W-1:0]  cmd_shift;
  logic [TW-1:0]       cmd_tag;
  logic [OPCODE_W-1:0] alu_opcode;
  logic [W-1:0]        alu_input1;
  logic [W-1:0]        alu_input2;
  logic [SHIFT_W-1:0]  alu_shiftValue;
  logic [W-1:0]        alu_result;
  logic                alu_carry;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [W-1:0]        rsp_result;
  logic                rsp_carry;
  logic                rsp_illegal;
  logic [TW-1:0]       rsp_tag;
  logic                busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(
    .WIDTH       (W),
    .FIFO_DEPTH  (DEPTH),
    .TAG_W       (TW),
    .MUL_LATENCY (ML)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_shift      (cmd_shift),
    .cmd_tag        (cmd_tag),
    .alu_opcode     (alu_opcode),
    .alu_input1     (alu_input1),
    .alu_input2     (alu_input2),
    .alu_shiftValue (alu_shiftValue),
    .alu_result     (alu_result),
    .alu_carry      (alu_carry),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_carry      (rsp_carry),
    .rsp_illegal    (rsp_illegal),
    .rsp_tag        (rsp_tag),
    .busy           (busy)
  );

  // Stand-in combinational ALU; its carry is deliberately 1 for non-arithmetic ops.
  typedef struct packed {
    logic         c;
    logic [W-1:0] r;
  } alu_out_t;

  function automatic alu_out_t alu_fn(input logic [OPCODE_W-1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [SHIFT_W-1:0] sh);
    alu_out_t    o;
    logic [W:0]  s;
    int unsigned n;
    n   = sh;
    o.c = 1'b1;
    o.r = '0;
    case (op)
      OP_ADD:   begin s = {1'b0, a} + {1'b0, b}; o.r = s[W-1:0]; o.c = s[W]; end
      OP_SUB:   begin o.r = a - b; o.c = (a < b); end
      OP_AND:   o.r = a & b;
      OP_OR:    o.r = a | b;
      OP_ROL:   o.r = (a << n) | (a >> (W - n));
      OP_PASSB: o.r = b;
      OP_ROR:   o.r = (a >> n) | (a << (W - n));
      OP_MUL:   o.r = a * b;
      default:  o.r = '0;
    endcase
    return o;
  endfunction

  alu_out_t alu_o;
  assign alu_o      = alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
  assign alu_result = alu_o.r;
  assign alu_carry  = alu_o.c;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: every accepted command yields exactly one response, in acceptance order.
  typedef struct {
    logic [W-1:0]  r;
    logic          c;
    logic          ill;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sbq[$];
  int            rsp_cnt = 0;
  logic          hold_q  = 1'b0;
  logic [W-1:0]  hold_r;
  logic          hold_c;
  logic          hold_i;
  logic [TW-1:0] hold_t;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      sbq.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk_i("hold_valid", int'(rsp_valid), 1);
        chk("hold_result", rsp_result, hold_r);
        chk_i("hold_flags", int'({rsp_carry, rsp_illegal}), int'({hold_c, hold_i}));
        chk_i("hold_tag", int'(rsp_tag), int'(hold_t));
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (sbq.size() == 0) begin
          chk_i("sb_unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_result", rsp_result, e.r);
          chk_i("sb_carry", int'(rsp_carry), int'(e.c));
          chk_i("sb_illegal", int'(rsp_illegal), int'(e.ill));
          chk_i("sb_tag", int'(rsp_tag), int'(e.tag));
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_t     e;
        alu_out_t o;
        o     = alu_fn(cmd_opcode, cmd_a, cmd_b, cmd_shift);
        e.r   = o.r;
        e.c   = (cmd_opcode == OP_ADD || cmd_opcode == OP_SUB) ? o.c : 1'b0;
        e.ill = (cmd_opcode > 4'd7);
        e.tag = cmd_tag;
        sbq.push_back(e);
        chk_i("sb_capacity_ok", int'(sbq.size() <= DEPTH + 1), 1);
      end
      hold_q = rsp_valid && !rsp_ready;
      hold_r = rsp_result;
      hold_c = rsp_carry;
      hold_i = rsp_illegal;
      hold_t = rsp_tag;
    end
  end

  task automatic push_cmd(input logic [OPCODE_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SHIFT_W-1:0] sh, input logic [TW-1:0] tg);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_shift  = sh;
    cmd_tag    = tg;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk_i("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk_i({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk_i({name, "_alu_opcode"}, int'(alu_opcode), 0);
    chk({name, "_alu_input1"}, alu_input1, '0);
    chk({name, "_alu_input2"}, alu_input2, '0);
    chk_i({name, "_alu_shift"}, int'(alu_shiftValue), 0);
    chk_i({name, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({name, "_rsp_result"}, rsp_result, '0);
    chk_i({name, "_rsp_flags"}, int'({rsp_carry, rsp_illegal}), 0);
    chk_i({name, "_rsp_tag"}, int'(rsp_tag), 0);
    chk_i({name, "_busy"}, int'(busy), 0);
    chk_i({name, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  typedef struct {
    logic [OPCODE_W-1:0] op;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic [SHIFT_W-1:0]  sh;
    logic [TW-1:0]       tag;
    logic [W-1:0]        r;
    logic                c;
    logic                ill;
    int                  lat;
  } vec_t;

  // Issue one command into an idle pipeline and time its response.
  task automatic run_vec(input string name, input vec_t v);
    int                  k;
    logic                stable;
    logic [OPCODE_W-1:0] s_op;
    logic [W-1:0]        s_a;
    logic [W-1:0]        s_b;
    logic [SHIFT_W-1:0]  s_sh;
    wait_idle(name);
    rsp_ready = 1'b1;
    push_cmd(v.op, v.a, v.b, v.sh, v.tag);
    k      = 0;
    stable = 1'b1;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        s_op = alu_opcode; s_a = alu_input1; s_b = alu_input2; s_sh = alu_shiftValue;
        chk({name, "_issue_a"}, alu_input1, v.a);
        chk_i({name, "_issue_op"}, int'(alu_opcode), int'(v.op));
      end else if (s_op !== alu_opcode || s_a !== alu_input1 || s_b !== alu_input2 || s_sh !== alu_shiftValue) begin
        stable = 1'b0;
      end
    end while (!rsp_valid && k < 40);
    chk_i({name, "_latency"}, k, v.lat);
    chk({name, "_result"}, rsp_result, v.r);
    chk_i({name, "_carry"}, int'(rsp_carry), int'(v.c));
    chk_i({name, "_illegal"}, int'(rsp_illegal), int'(v.ill));
    chk_i({name, "_tag"}, int'(rsp_tag), int'(v.tag));
    chk_i({name, "_alu_stable"}, int'(stable), 1);
    @(posedge clk);
    #1;
    chk_i({name, "_rsp_drop"}, int'(rsp_valid), 0);
    chk_i({name, "_busy_after"}, int'(busy), 0);
  endtask

  vec_t vt [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    int   base;
    logic acc;
    logic stale;
    vec_t pb;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shift = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_i("post_reset_cmd_ready", int'(cmd_ready), 1);

    vt[0]  = '{OP_ADD,   {W{1'b1}},      128'd1,         5'd0, 4'd3,  128'd0,          1'b1, 1'b0, 2};
    vt[1]  = '{OP_SUB,   128'd5,         128'd7,         5'd0, 4'd1,  ~128'd1,         1'b1, 1'b0, 2};
    vt[2]  = '{OP_AND,   128'hF0,        128'h3C,        5'd0, 4'd2,  128'h30,         1'b0, 1'b0, 2};
    vt[3]  = '{OP_MUL,   128'd3,         128'd4,         5'd0, 4'd4,  128'd12,         1'b0, 1'b0, 2 + ML};
    vt[4]  = '{4'd9,     128'd5,         128'd6,         5'd3, 4'd5,  128'd0,          1'b0, 1'b1, 2};
    vt[5]  = '{OP_ROL,   128'd1,         128'd0,         5'd5, 4'd6,  128'd32,         1'b0, 1'b0, 2};
    vt[6]  = '{OP_ROR,   128'd1,         128'd0,         5'd1, 4'd7,  128'd1 << 127,   1'b0, 1'b0, 2};
    vt[7]  = '{OP_OR,    128'hF0,        128'h0F,        5'd0, 4'd8,  128'hFF,         1'b0, 1'b0, 2};
    vt[8]  = '{OP_ADD,   128'd1,         128'd1,         5'd0, 4'd9,  128'd2,          1'b0, 1'b0, 2};
    vt[9]  = '{4'd15,    {W{1'b1}},      {W{1'b1}},      5'd0, 4'd15, 128'd0,          1'b0, 1'b1, 2};
    vt[10] = '{OP_MUL,   128'd1 << 64,   128'd1 << 64,   5'd0, 4'd10, 128'd0,          1'b0, 1'b0, 2 + ML};
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Stall the consumer: one command executes, four fill the FIFO, the sixth is refused.
    wait_idle("bp_pre");
    rsp_ready = 1'b0;
    base = rsp_cnt;
    for (int t = 0; t < 5; t++) push_cmd(OP_ADD, W'(t), 128'd1, 5'd0, TW'(t));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_a = 128'd5; cmd_b = 128'd1; cmd_shift = '0; cmd_tag = 4'd5;
    chk_i("bp_sixth_refused", int'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    chk_i("bp_still_refused", int'(cmd_ready), 0);
    chk_i("bp_rsp_waiting", int'(rsp_valid), 1);
    chk_i("bp_head_tag", int'(rsp_tag), 0);
    chk("bp_head_result", rsp_result, 128'd1);
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_i("bp_sixth_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle("bp_drain");
    chk_i("bp_rsp_count", rsp_cnt - base, 6);
    chk_i("bp_queue_empty", sbq.size(), 0);

    // Random traffic with random consumer backpressure.
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cmd_valid || acc) begin
        cmd_valid  = ($urandom_range(0, 3) != 0);
        cmd_opcode = OPCODE_W'($urandom_range(0, 15));
        cmd_a      = {$urandom(), $urandom(), $urandom(), $urandom()};
        cmd_b      = {$urandom(), $urandom(), $urandom(), $urandom()};
        cmd_shift  = SHIFT_W'($urandom_range(0, 31));
        cmd_tag    = TW'($urandom_range(0, 15));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      acc = cmd_valid && cmd_ready;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand_drain");
    chk_i("rand_queue_empty", sbq.size(), 0);

    // Reset during a MUL wait with two commands still queued.
    rsp_ready = 1'b1;
    push_cmd(OP_MUL, 128'd3, 128'd4, 5'd0, 4'd1);
    push_cmd(OP_ADD, 128'd1, 128'd1, 5'd0, 4'd2);
    push_cmd(OP_ADD, 128'd2, 128'd2, 5'd0, 4'd3);
    @(negedge clk);
    chk_i("rm_busy_before", int'(busy), 1);
    chk_i("rm_no_rsp_yet", int'(rsp_valid), 0);
    chk_i("rm_mul_issued", int'(alu_opcode), int'(OP_MUL));
    rst = 1'b1;
    #1;
    check_zero_outputs("rm_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) stale = 1'b1;
    end
    chk_i("rm_no_stale_rsp", int'(stale), 0);
    chk_i("rm_idle_after", int'(busy), 0);
    pb = '{OP_PASSB, 128'd0, 128'hAA, 5'd0, 4'd6, 128'hAA, 1'b0, 1'b0, 2};
    run_vec("rm_passb", pb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
Upstream feeder and result collector for the 128-bit combinational ALU (opcodes ADD/SUB/AND/OR/ROL/PASSB/ROR/MUL, carry flag). It accepts tagged commands over a valid/ready stream and buffers them in a small FIFO. It drives registered, stable operands into the ALU, holds them for a multicycle MUL, then captures result and carry into a valid/ready response register. Sits between the command source and the ALU instance.

Parameters:
WIDTH, 128, operand/result width; must match the ALU instance
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the command tag echoed on the response
MUL_LATENCY, 3, extra cycles operands are held stable before a MUL result is captured (multicycle path; 0 allowed)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
cmd_opcode  in  4  ALU opcode
cmd_a  in  WIDTH  operand 1
cmd_b  in  WIDTH  operand 2
cmd_shift  in  5  rotate amount
cmd_tag  in  TAG_W  caller tag
alu_opcode  out  4  to ALU opcode
alu_input1  out  WIDTH  to ALU input1
alu_input2  out  WIDTH  to ALU input2
alu_shiftValue  out  5  to ALU shiftValue
alu_result  in  WIDTH  from ALU result
alu_carry  in  1  from ALU carryFlag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured result
rsp_carry  out  1  captured carry (ADD/SUB only, else 0)
rsp_illegal  out  1  opcode 8..15 was issued
rsp_tag  out  TAG_W  echoed tag
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (async assert, sync deassert-safe): FIFO empty, state IDLE, all outputs 0 (alu_* 0, rsp_* 0, busy 0); cmd_ready reads 1 once reset is low.
- cmd_ready = !fifo_full; no combinational path from rsp_ready or alu_* to cmd_ready. Push on cmd_valid && cmd_ready.
- States: IDLE, EXEC, RESP.
- IDLE: if FIFO non-empty, pop head into alu_* registers and the tag register; load cnt = (opcode==MUL) ? MUL_LATENCY : 0; go to EXEC.
- EXEC: alu_* stay stable. If cnt!=0, decrement. If cnt==0, capture into the response register and go to RESP with rsp_valid=1:
  - rsp_result = alu_result
  - rsp_carry = alu_carry when opcode is ADD/SUB, else 0
  - rsp_illegal = (opcode>7)
  - rsp_tag = the held tag
- Illegal opcodes (8..15) are still issued. The ALU yields 0, so rsp_result=0, carry 0, rsp_illegal=1, with no MUL wait.
- RESP: rsp_* held stable until rsp_valid && rsp_ready. On that edge:
  - if the FIFO is non-empty, pop directly into EXEC (back-to-back, no IDLE bubble) and rsp_valid drops to 0;
  - otherwise go to IDLE with rsp_valid 0.
- Latency: accept at edge N -> rsp_valid high after edge N+2 (non-MUL) or N+2+MUL_LATENCY (MUL), when the pipeline is idle.
- Throughput: one command per 2 cycles (non-MUL) with rsp_ready tied high.
- Ordering: strictly in order. In-flight capacity is FIFO_DEPTH + 1 (executing/responding).
- Simultaneous push and pop: allowed whenever not full. Count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: drops all queued and in-flight commands; no response is produced for them.
- Width rules: no arithmetic in this block except cnt (width clog2(MUL_LATENCY+1), min 1) and FIFO pointers/count (clog2(FIFO_DEPTH)+1).

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD=0, SUB=1, AND=2, OR=3, ROL=4, PASSB=5, ROR=6, MUL=7), OPCODE_W=4, SHIFT_W=5, state encoding.
- Sub-module alu_cmd_fifo: synchronous FIFO with parameterised width/depth and full/empty/count, storing {opcode, a, b, shift, tag}.
- Sequencer FSM and response register live in the top.

Test Plan:
- ADD a=2^128-1, b=1, tag=3, rsp_ready=1 -> rsp_valid 2 cycles after accept; result 0, carry 1, tag 3, illegal 0.
- SUB a=5, b=7 -> result 2^128-2, carry per ALU flag; then AND a=0xF0, b=0x3C -> result 0x30, carry forced 0.
- MUL a=3, b=4, MUL_LATENCY=3 -> alu_* stable 4 cycles; rsp_valid exactly 5 cycles after accept; result 12.
- rsp_ready=0, push 6 ADDs back-to-back -> 1 executes, 4 fill FIFO, cmd_ready low from the 6th; release rsp_ready -> responses emerge in tag order 0..5, none lost or duplicated.
- Opcode 9 -> result 0, rsp_illegal 1, latency 2; then ROL a=1, shift=5 -> result 32.
- Assert rst during a MUL wait with 2 queued -> all outputs 0 immediately; after release, no stale response appears and a new PASSB b=0xAA returns 0xAA.
